// File: rtl/uart_tx_fifo_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_buffer : circular transmit FIFO with busy-handshake FSM
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo_buffer #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH_LOG2        = 4,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int BUSY_TIMEOUT      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  dataReady,
  input  logic                  txBusy,
  input  logic                  clearOverflow,
  output logic                  txStart,
  output logic [DATA_WIDTH-1:0] txData,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int                DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LEVEL   = (DEPTH_LOG2 + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [7:0]        TIMEOUT    = 8'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_next;
  logic [7:0] cnt, cnt_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;

  logic pop, push, ovf_evt;

  assign empty      = (level == '0);
  assign full       = (level == FULL_LEVEL);
  assign almostFull = (level >= AF_LEVEL);

  // A pop frees a slot in the same cycle, so a push at full is still accepted.
  assign pop     = (state == IDLE) && !empty && !txBusy;
  assign push    = dataReady && (!full || pop);
  assign ovf_evt = dataReady && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      txStart  <= 1'b0;
      txData   <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      txStart <= pop;
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr   <= rptr + PTR_ONE;
        txData <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clearOverflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = START;
        end
      end
      START: begin
        cnt_next   = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Lost handshake: give up and treat the byte as sent.
        if (txBusy) begin
          state_next = WAIT_DONE;
        end else if (cnt >= TIMEOUT) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!txBusy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_buffer : self-checking bench with a queue-based reference model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_buffer;

  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int AFL   = 12;
  localparam int BT    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data = '0;
  logic          dataReady = 1'b0;
  logic          txBusy = 1'b0;
  logic          clearOverflow = 1'b0;
  logic          txStart;
  logic [DW-1:0] txData;
  logic          full, empty, almostFull, overflow;
  logic [DL:0]   level;

  int vectors = 0;
  int errors  = 0;

  // Reference model: FIFO contents as a queue plus the transmit handshake
  // tracked as "edges since the last start pulse".
  logic [7:0] q[$];
  bit         m_ovf, m_start, m_idle, m_wd;
  logic [7:0] m_data;
  int         m_k;

  uart_tx_fifo_buffer #(
    .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .ALMOST_FULL_LEVEL(AFL), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dataReady(dataReady), .txBusy(txBusy),
    .clearOverflow(clearOverflow), .txStart(txStart), .txData(txData),
    .full(full), .empty(empty), .almostFull(almostFull), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_start = 0; m_idle = 1; m_wd = 0; m_k = 0; m_data = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs applied before it.
  task automatic tick();
    bit pop, acc, was_full;
    was_full = (q.size() == DEPTH);
    pop = 0;
    if (m_idle) begin
      pop = (q.size() != 0) && !txBusy;
    end else begin
      m_k++;
      if (m_k >= 2) begin
        if (m_wd) begin
          if (!txBusy) m_idle = 1;
        end else if (txBusy) begin
          m_wd = 1;
        end else if (m_k - 2 >= BT) begin
          m_idle = 1;
        end
      end
    end
    acc = dataReady && (!was_full || pop);
    if (dataReady && was_full && !pop) m_ovf = 1;
    else if (clearOverflow) m_ovf = 0;
    m_start = pop;
    if (pop) begin
      m_data = q.pop_front();
      m_idle = 0; m_k = 0; m_wd = 0;
    end
    if (acc) q.push_back(data);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_model_idle();
    for (int c = 0; c < 50 && !m_idle; c++) tick();
  endtask

  task automatic test_reset();
    rst = 0; dataReady = 0; txBusy = 0; clearOverflow = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (level !== 0)      begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (almostFull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", almostFull); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    vectors++; if (txStart !== 1'b0) begin errors++; $display("FAIL reset_txstart got %b want 0", txStart); end
    vectors++; if (txData !== 8'h00) begin errors++; $display("FAIL reset_txdata got %h want 00", txData); end
    rst = 1;
    tick();
  endtask

  task automatic test_single();
    data = 8'h41; dataReady = 1; txBusy = 0;
    tick();
    dataReady = 0;
    vectors++; if (level !== 1) begin errors++; $display("FAIL single_level1 got %0d want 1", level); end
    vectors++; if (txStart !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", txStart); end
    tick();
    vectors++; if (txStart !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", txStart); end
    vectors++; if (txData !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", txData); end
    vectors++; if (level !== 0) begin errors++; $display("FAIL single_level0 got %0d want 0", level); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
    tick();
    vectors++; if (txStart !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", txStart); end
    vectors++; if (txData !== 8'h41) begin errors++; $display("FAIL single_hold got %h want 41", txData); end
    wait_model_idle();
  endtask

  task automatic test_burst();
    int sent = 0, busy_left = 0;
    txBusy = 1;
    for (int i = 0; i < 10; i++) begin
      data = 8'(8'h41 + i); dataReady = 1;
      tick();
    end
    dataReady = 0;
    vectors++; if (level !== 10) begin errors++; $display("FAIL burst_level got %0d want 10", level); end
    vectors++; if (almostFull !== 1'b0) begin errors++; $display("FAIL burst_afull got %b want 0", almostFull); end
    txBusy = 0;
    for (int c = 0; c < 400 && sent < 10; c++) begin
      tick();
      vectors++; if (txStart !== m_start) begin errors++; $display("FAIL burst_start got %b want %b", txStart, m_start); end
      if (txStart) begin
        vectors++;
        if (txData !== 8'(8'h41 + sent)) begin errors++; $display("FAIL burst_data got %h want %h", txData, 8'(8'h41 + sent)); end
        sent++;
        busy_left = 8;
      end
      txBusy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
    end
    vectors++; if (sent != 10) begin errors++; $display("FAIL burst_count got %0d want 10", sent); end
    vectors++; if (level !== 0) begin errors++; $display("FAIL burst_end_level got %0d want 0", level); end
    for (int c = 0; c < 20 && txBusy; c++) begin
      tick();
      txBusy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
    end
    wait_model_idle();
  endtask

  task automatic test_overflow();
    txBusy = 1;
    for (int i = 0; i < 17; i++) begin
      data = 8'(i); dataReady = 1;
      tick();
      if (i == 15) begin
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
        vectors++; if (level !== 16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    dataReady = 0;
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    vectors++; if (level !== 16) begin errors++; $display("FAIL ovf_level_kept got %0d want 16", level); end
    tick();
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clearOverflow = 1;
    tick();
    clearOverflow = 0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  // FIFO is full with 0x00..0x0F; release txBusy and push 0xAA in the pop cycle.
  // txBusy then stays low, so every byte takes the timeout path.
  task automatic test_full_push_pop();
    int sent = 1, last = 0;
    logic [7:0] want;
    txBusy = 0; data = 8'hAA; dataReady = 1;
    tick();
    dataReady = 0;
    vectors++; if (txStart !== 1'b1) begin errors++; $display("FAIL fpp_start got %b want 1", txStart); end
    vectors++; if (txData !== 8'h00) begin errors++; $display("FAIL fpp_data got %h want 00", txData); end
    vectors++; if (level !== 16) begin errors++; $display("FAIL fpp_level got %0d want 16", level); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    for (int c = 1; c < 300 && sent < 17; c++) begin
      tick();
      if (txStart) begin
        want = (sent < 16) ? 8'(sent) : 8'hAA;
        vectors++; if (txData !== want) begin errors++; $display("FAIL fpp_order got %h want %h", txData, want); end
        vectors++; if (c - last != BT + 3) begin errors++; $display("FAIL timeout_spacing got %0d want %0d", c - last, BT + 3); end
        last = c;
        sent++;
      end
    end
    vectors++; if (sent != 17) begin errors++; $display("FAIL fpp_count got %0d want 17", sent); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got %b want 1", empty); end
    wait_model_idle();
  endtask

  task automatic test_reset_mid_drain();
    int starts = 0;
    txBusy = 1;
    for (int i = 0; i < 6; i++) begin
      data = 8'(8'h60 + i); dataReady = 1;
      tick();
    end
    dataReady = 0; txBusy = 0;
    tick();
    vectors++; if (level !== 5) begin errors++; $display("FAIL rmd_level got %0d want 5", level); end
    #2 rst = 0;
    #1;
    vectors++; if (level !== 0) begin errors++; $display("FAIL rmd_async_level got %0d want 0", level); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rmd_empty got %b want 1", empty); end
    vectors++; if (txStart !== 1'b0) begin errors++; $display("FAIL rmd_txstart got %b want 0", txStart); end
    vectors++; if (txData !== 8'h00) begin errors++; $display("FAIL rmd_txdata got %h want 00", txData); end
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (txStart) starts++;
    end
    vectors++; if (starts != 0) begin errors++; $display("FAIL rmd_spurious got %0d want 0", starts); end
    data = 8'h5A; dataReady = 1;
    tick();
    dataReady = 0;
    tick();
    vectors++; if (txStart !== 1'b1) begin errors++; $display("FAIL rmd_restart got %b want 1", txStart); end
    vectors++; if (txData !== 8'h5A) begin errors++; $display("FAIL rmd_redata got %h want 5a", txData); end
    wait_model_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      dataReady     = ($urandom_range(0, 99) < 45);
      data          = 8'($urandom);
      txBusy        = ($urandom_range(0, 3) == 0);
      clearOverflow = ($urandom_range(0, 19) == 0);
      tick();
      vectors++; if (int'(level) != q.size()) begin errors++; $display("FAIL rnd_level got %0d want %0d", level, q.size()); end
      vectors++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full got %b", full); end
      vectors++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty got %b", empty); end
      vectors++; if (almostFull !== (q.size() >= AFL)) begin errors++; $display("FAIL rnd_afull got %b", almostFull); end
      vectors++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf got %b want %b", overflow, m_ovf); end
      vectors++; if (txStart !== m_start) begin errors++; $display("FAIL rnd_start got %b want %b", txStart, m_start); end
      if (m_start) begin
        vectors++; if (txData !== m_data) begin errors++; $display("FAIL rnd_data got %h want %h", txData, m_data); end
      end
    end
    dataReady = 0; clearOverflow = 0; txBusy = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_buffer.md
Name: uart_tx_fifo_buffer

Overview:
Parametrised transmit-side buffer between a byte producer and the UART transmitter. It replaces the single-entry transmit buffer with a circular FIFO of configurable width and depth. The block adds full/empty/almost-full status, a fill level, a sticky overflow flag and a busy-handshake FSM with timeout. It sits between application logic (dataReady/data) and uart_tx (txStart/txData/txBusy).

Parameters:
DATA_WIDTH, 8, width of data, txData and each FIFO entry.
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16 by default); legal range 1..8.
ALMOST_FULL_LEVEL, 12, almostFull asserts when level >= this value; legal range 1..2**DEPTH_LOG2.
BUSY_TIMEOUT, 4, cycles to wait for txBusy to rise after txStart; legal range 1..255.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  asynchronous, active-low reset: assertion (0) resets immediately, deassertion is synchronous to clk.
data  input  DATA_WIDTH  byte to enqueue; sampled when dataReady=1.
dataReady  input  1  push strobe; one entry is pushed per clk cycle in which it is high.
txBusy  input  1  high while uart_tx is shifting a frame.
clearOverflow  input  1  synchronous clear of overflow.
txStart  output  1  one-cycle start pulse to uart_tx.
txData  output  DATA_WIDTH  byte for uart_tx; valid in the txStart cycle and held until the next txStart.
full  output  1  level == 2**DEPTH_LOG2.
empty  output  1  level == 0.
almostFull  output  1  level >= ALMOST_FULL_LEVEL.
level  output  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2.
overflow  output  1  sticky; a push was dropped.

Behaviour:
- Reset (rst=0): read/write pointers=0, level=0, txStart=0, txData=0, overflow=0, FSM=IDLE. Consequently empty=1, full=0 and almostFull=0. Reset applies mid-frame as well: the FIFO contents are discarded and no further txStart is issued.
- Storage: circular buffer, pointers DEPTH_LOG2 bits wide, wrapping naturally from 2**DEPTH_LOG2-1 to 0. full and empty derive from a registered level counter, not from pointer compare alone.
- Push: accepted when dataReady=1 and (full=0, or a pop occurs in the same cycle). On acceptance, data is written at wptr and wptr increments.
- Overflow: dataReady=1 while full=1 with no pop in that cycle drops the byte and sets overflow=1. Storage and level are unchanged.
  - overflow stays set until clearOverflow=1. If clearOverflow and a new overflow event occur in the same cycle, overflow stays 1 (set wins).
- Level update: level increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - Simultaneous push and pop at full: level stays at 2**DEPTH_LOG2.
  - Simultaneous push and pop at empty cannot occur, because a pop requires empty=0 in the prior cycle state.
- FSM, IDLE: if empty=0 and txBusy=0, then at the next edge:
  - txData <= mem[rptr], rptr increments (pop), txStart <= 1;
  - go to START.
  Otherwise stay in IDLE.
- FSM, START: txStart <= 0, timeout counter <= 0, go to WAIT_BUSY. txStart is therefore high for exactly one cycle.
- FSM, WAIT_BUSY:
  - txBusy=1 goes to WAIT_DONE.
  - Otherwise the counter increments; when it reaches BUSY_TIMEOUT, go to IDLE (lost-handshake recovery, the byte is considered sent).
- FSM, WAIT_DONE: txBusy=0 goes to IDLE.
- Latency:
  - A byte pushed into an empty FIFO at edge N (txBusy=0) gives txStart=1 with txData=that byte during cycle N+1 to N+2. level returns to 0 at edge N+1.
  - Back-to-back bytes: minimum spacing between txStart pulses is 3 cycles plus the txBusy high time (or plus BUSY_TIMEOUT).
- txBusy=1 in IDLE: entries remain queued and no txStart is issued until txBusy=0.
- Ordering: strict FIFO order; no byte is duplicated or reordered.

Test Plan:
- Reset then push 0x41 with txBusy=0 -> txStart pulses 1 cycle later with txData=0x41; level goes 1->0; empty=1 afterwards.
- Push 0x41..0x4A on consecutive cycles with txBusy held 1 -> level=10, almostFull=0. Then model uart_tx (txBusy high 8 cycles after each txStart) -> txStart pulses carry 0x41..0x4A in order, level ends at 0.
- Push 17 bytes (0x00..0x10) with txBusy=1, DEPTH_LOG2=4 -> full=1 and level=16 after the 16th push; 17th push sets overflow=1.
  - Assert clearOverflow -> overflow=0.
  - Release txBusy -> bytes drain as 0x00..0x0F, and 0x10 is never sent.
- FIFO full with txBusy falling, and dataReady=1 with data=0xAA in the pop cycle -> push accepted, level stays 16, overflow stays 0, and 0xAA is eventually sent last.
- txBusy never rises after txStart, BUSY_TIMEOUT=4 -> FSM returns to IDLE 5 cycles after the pulse and the next queued byte is started; no lock-up.
- rst driven low for 1 cycle mid-drain with level=5 -> level=0, empty=1, txStart=0, txData=0 immediately (asynchronous). No txStart after rst returns high until a new push.
